// File: rtl/vsync_phase_det.sv
`default_nettype none
// ============================================================================
// vsync_phase_det : measures external Vsync phase against a vref-timed window
// Rev 1.0
// ============================================================================
module vsync_phase_det #(
    parameter int PW     = 21,
    parameter int ERRW   = 22,
    parameter int HIT_N  = 3,
    parameter int MISS_N = 4
) (
    input  logic            sp_clk,
    input  logic            rst,
    input  logic            vsync_in,
    input  logic            vref,
    input  logic [PW-1:0]   win_delay,
    input  logic [9:0]      win_width,
    input  logic [ERRW-1:0] dlim,
    output logic [ERRW-1:0] err,
    output logic            sample,
    output logic            pd_error,
    output logic            venable
);

    localparam int HCW = $clog2(HIT_N + 1);
    localparam int MCW = $clog2(MISS_N + 1);
    localparam logic [HCW-1:0] C_HIT_N  = HCW'(HIT_N);
    localparam logic [MCW-1:0] C_MISS_N = MCW'(MISS_N);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [2:0]             r_sync;
    logic [PW-1:0]          r_pcnt;
    logic [HCW-1:0]         r_hit_cnt;
    logic [MCW-1:0]         r_miss_cnt;
    logic [ERRW-1:0]        r_err;
    logic                   r_sample;
    logic                   r_pd_error;
    logic                   r_venable;

    logic                   w_vs_det;
    logic [PW-1:0]          w_pcnt_eval;
    logic signed [PW:0]     w_diff_wide;
    logic signed [ERRW-1:0] w_diff;
    logic signed [ERRW-1:0] w_ww;
    logic signed [ERRW-1:0] w_lim;
    logic signed [ERRW-1:0] w_clamped;
    logic [PW+1:0]          w_limit;
    logic                   w_in_win;
    logic                   w_eval;
    logic                   w_timeout;
    logic                   w_hit;
    logic                   w_miss;
    logic [HCW-1:0]         w_hit_nxt;
    logic [MCW-1:0]         w_miss_nxt;
    logic                   w_unused_dlim_msb;

    assign w_unused_dlim_msb = dlim[ERRW-1];

    // Two-flop synchroniser plus one history flop for rising-edge detection
    always_ff @(posedge sp_clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[1:0], vsync_in};
        end
    end

    assign w_vs_det = r_sync[1] & ~r_sync[2];

    always_ff @(posedge sp_clk or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (vref) begin
            r_pcnt <= '0;
        end else if (r_pcnt != '1) begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    // A vs_det coincident with vref is measured against the cleared counter
    assign w_pcnt_eval = vref ? '0 : r_pcnt;
    assign w_diff_wide = $signed({1'b0, w_pcnt_eval}) - $signed({1'b0, win_delay});
    assign w_diff      = ERRW'(w_diff_wide);
    assign w_ww        = ERRW'({1'b0, win_width});
    assign w_lim       = $signed({1'b0, dlim[ERRW-2:0]});
    assign w_in_win    = (w_diff >= -w_ww) && (w_diff <= w_ww);

    always_comb begin
        w_clamped = w_diff;
        if (w_diff > w_lim) begin
            w_clamped = w_lim;
        end else if (w_diff < -w_lim) begin
            w_clamped = -w_lim;
        end
    end

    assign w_limit   = {2'b00, win_delay} + (PW+2)'(win_width) + (PW+2)'(1);
    assign w_eval    = w_vs_det && (vref || (r_state == S_ARMED));
    assign w_timeout = (r_state == S_ARMED) && !vref && !w_vs_det
                       && ({2'b00, r_pcnt} >= w_limit);
    assign w_hit     = w_eval && w_in_win;
    assign w_miss    = (w_eval && !w_in_win) || w_timeout;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (vref) begin
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (vref) begin
                    w_state_nxt = S_ARMED;
                end else if (w_vs_det || w_timeout) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (vref) begin
                    w_state_nxt = S_ARMED;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sp_clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_hit_nxt  = r_hit_cnt;
        w_miss_nxt = r_miss_cnt;
        if (w_hit) begin
            w_miss_nxt = '0;
            if (r_hit_cnt != C_HIT_N) begin
                w_hit_nxt = r_hit_cnt + 1'b1;
            end
        end else if (w_miss) begin
            w_hit_nxt = '0;
            if (r_miss_cnt != C_MISS_N) begin
                w_miss_nxt = r_miss_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge sp_clk or posedge rst) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_err      <= '0;
            r_sample   <= 1'b0;
            r_pd_error <= 1'b0;
            r_venable  <= 1'b0;
        end else begin
            r_hit_cnt  <= w_hit_nxt;
            r_miss_cnt <= w_miss_nxt;
            r_sample   <= w_hit;
            r_pd_error <= w_miss;
            if (w_hit) begin
                r_err <= w_clamped;
            end
            if (w_hit && (w_hit_nxt == C_HIT_N)) begin
                r_venable <= 1'b1;
            end else if (w_miss && (w_miss_nxt == C_MISS_N)) begin
                r_venable <= 1'b0;
            end
        end
    end

    assign err      = r_err;
    assign sample   = r_sample;
    assign pd_error = r_pd_error;
    assign venable  = r_venable;

endmodule
`default_nettype wire

// File: doc/vsync_phase_det.md
VSYNC_PHASE_DET -- requirements
Module: vsync_phase_det

Interface
REQ-001 SHALL have parameter PW, default 21, which sets the width of the phase counter and of win_delay.
REQ-002 SHALL have parameter ERRW, default 22, which sets the width of the signed error and of dlim.
REQ-003 SHALL have parameter HIT_N, default 3, the number of consecutive in-window samples needed to assert venable.
REQ-004 SHALL have parameter MISS_N, default 4, the number of consecutive misses needed to deassert venable.
REQ-005 SHALL have port sp_clk, input, 1 bit: the single system clock (50 MHz); all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port vsync_in, input, 1 bit: external Vsync, asynchronous to sp_clk.
REQ-008 SHALL have port vref, input, 1 bit: frame reference strobe, one cycle wide, synchronous to sp_clk.
REQ-009 SHALL have port win_delay, input, PW bits, unsigned: expected Vsync position in sp_clk cycles after vref.
REQ-010 SHALL have port win_width, input, 10 bits, unsigned: acceptance half-width in cycles.
REQ-011 SHALL have port dlim, input, ERRW bits: error clamp magnitude; only bits [ERRW-2:0] are used.
REQ-012 SHALL have port err, output, ERRW bits, two's complement: phase error, positive when Vsync is late.
REQ-013 SHALL have port sample, output, 1 bit: one-cycle strobe marking that err was updated.
REQ-014 SHALL have port pd_error, output, 1 bit: one-cycle strobe for an out-of-window edge or a timeout.
REQ-015 SHALL have port venable, output, 1 bit: lock indicator.

Function
REQ-016 SHALL synchronise vsync_in through two flip-flops, then rising-edge detect it to form vs_det, a one-cycle strobe.
REQ-017 SHALL run a state machine with states IDLE, ARMED and WAIT.
- IDLE→ARMED on vref.
- ARMED→WAIT on vs_det or on timeout.
- WAIT→ARMED on vref.
REQ-018 SHALL clear phase counter pcnt to 0 on every vref; otherwise pcnt increments each cycle and saturates at all-ones, without wrapping.
REQ-019 SHALL compute diff = {0,pcnt} − {0,win_delay} as an ERRW-bit signed value using the pcnt value in the vs_det cycle.
REQ-020 SHALL classify a vs_det in ARMED as a hit when −win_width ≤ diff ≤ +win_width, both bounds inclusive; any other diff is a miss.
REQ-021 SHALL, on a hit, register err = clamp(diff, −dlim[ERRW-2:0], +dlim[ERRW-2:0]) and pulse sample, both one cycle after the vs_det cycle.
REQ-022 SHALL, on a miss, pulse pd_error one cycle after the vs_det cycle and leave err unchanged.
REQ-023 SHALL treat pcnt reaching win_delay+win_width+1 in ARMED with no vs_det as a timeout: pd_error pulses the following cycle, the state goes to WAIT, and it counts as a miss.
REQ-024 SHALL ignore vs_det while in IDLE or WAIT, with no strobes and no counter change.
REQ-025 SHALL, when vref and vs_det occur in the same cycle, give vref priority: pcnt clears and the state is ARMED.
- The vs_det in that cycle is evaluated with pcnt=0, so diff = −win_delay.
REQ-026 SHALL keep a hit counter and a miss counter, each saturating.
- A hit clears the miss counter.
- A miss clears the hit counter.
REQ-027 SHALL set venable in the cycle the hit counter reaches HIT_N, and clear it in the cycle the miss counter reaches MISS_N.
REQ-028 SHALL never assert sample and pd_error in the same cycle.
REQ-029 SHALL sample win_delay, win_width and dlim in the vs_det or timeout cycle only; changes at other times take effect at the next evaluation.

Reset
REQ-030 SHALL, while rst is high, force the following values:
- state IDLE;
- pcnt 0;
- synchroniser flops 0;
- hit and miss counters 0;
- err 0;
- sample 0, pd_error 0, venable 0.
REQ-031 SHALL, on rst asserted mid-ARMED, abort the pending measurement with no strobe; after rst release the first evaluation requires a fresh vref.

Verification
REQ-032 Setup: win_delay=1000, win_width=100, dlim=50; rst, then vref, then vs_det at pcnt=1030 → one cycle later err=+30 and sample=1 for exactly 1 cycle; after 3 such frames venable=1.
REQ-033 vs_det at pcnt=1080 → err=+50 (clamped), sample pulses; vs_det at pcnt=900 → err=−50 (clamped).
REQ-034 vs_det at pcnt=899 → pd_error pulses, err holds its previous value, hit counter clears; vs_det at pcnt=900 and 1100 → hits (boundary).
REQ-035 After lock, no vsync_in for 4 frames → pd_error pulses at pcnt=1101 each frame and venable=0 after the 4th; a second vs_det within one frame is ignored.
REQ-036 vref and vs_det in the same cycle → diff=−1000, pd_error pulses, state ARMED; rst pulse mid-ARMED → all outputs 0, and vs_det before the next vref produces no strobe.
